// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state encodings and default width for serial_subtractor
package serial_sub_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/busy/done operand and result bundle for serial_subtractor
// ovf exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
   parameter int WIDTH = serial_sub_pkg::DEFAULT_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf;

   modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
   modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
`else
   modport master (output start, a, b, bin, input busy, done, diff, bout);
   modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/full_subtractor_cell.sv
// rtl/full_subtractor_cell.sv - combinational one-bit full subtractor (X - Y - Z)
module full_subtractor_cell (
   input  logic X,
   input  logic Y,
   input  logic Z,
   output logic D,
   output logic B
);

   assign D = X ^ Y ^ Z;
   assign B = (~X & Y) | (~X & Z) | (Y & Z);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin, LSB first, one cell plus a borrow flop
// Optional signed-overflow output enabled by SERIAL_SUB_OVF_EN.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                clk,
   input  logic                rst,
   serial_subtractor_if.slave  bus
);

   localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic [WIDTH-1:0] r_diff;
   logic [CW-1:0]    r_cnt;
   logic             r_brw;
   logic             r_bout;
   logic             r_busy;
   logic             r_done;
   logic             w_d;
   logic             w_b;
   logic             w_accept;
   logic             w_last;

   full_subtractor_cell u_cell (
      .X (r_a_sr[0]),
      .Y (r_b_sr[0]),
      .Z (r_brw),
      .D (w_d),
      .B (w_b)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_accept    = 1'b1;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (r_cnt == LAST) begin
               w_last      = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // busy/done are registered from the next state so they line up with r_state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_sr <= '0;
         r_b_sr <= '0;
         r_diff <= '0;
         r_cnt  <= '0;
         r_brw  <= 1'b0;
         r_bout <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_busy <= (w_state_nxt == S_SHIFT);
         r_done <= (w_state_nxt == S_DONE);
         if (w_accept) begin
            r_a_sr <= bus.a;
            r_b_sr <= bus.b;
            r_brw  <= bus.bin;
            r_cnt  <= '0;
            r_diff <= '0;
            r_bout <= 1'b0;
         end else if (r_state == S_SHIFT) begin
            r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
            r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
            r_diff <= {w_d, r_diff[WIDTH-1:1]};
            r_brw  <= w_b;
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) begin
               r_bout <= w_b;
            end
         end
      end
   end

`ifdef SERIAL_SUB_OVF_EN
   logic r_ovf;

   // Borrow into the MSB differing from borrow out of it marks signed overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (w_accept) begin
         r_ovf <= 1'b0;
      end else if (w_last) begin
         r_ovf <= r_brw ^ w_b;
      end
   end

   assign bus.ovf = r_ovf;
`endif

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.diff = r_diff;
   assign bus.bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed and back-to-back checks for serial_subtractor
module tb_serial_subtractor;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   serial_subtractor_if #(.WIDTH(W)) intf ();

   serial_subtractor #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (intf)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] d;
      logic       bo;
      logic       ov;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic mbin);
      logic [8:0] t;
      logic       ov;
      t  = {1'b0, ma} - {1'b0, mb} - {8'b0, mbin};
      ov = (ma[7] ^ mb[7]) & (t[7] ^ ma[7]);
      return {ov, t};
   endfunction

   // Called at a negedge in IDLE; returns at the negedge where done is seen.
   task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin, output int edges);
      intf.a     = ta;
      intf.b     = tb;
      intf.bin   = tbin;
      intf.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      intf.start = 1'b0;
      intf.a     = ~ta;
      intf.b     = ~tb;
      intf.bin   = ~tbin;
      check("busy_after_start", {31'b0, intf.busy}, 32'd1);
      edges = 0;
      while (intf.done !== 1'b1 && edges < 40) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
   endtask

   initial begin
      int         edges;
      int         pulses;
      int         dcyc;
      int         cyc;
      int         last;
      int         k;
      logic       s;
      logic [7:0] ca;
      logic [7:0] cb;
      logic       cbin;
      logic [9:0] m;

      vecs[0] = {8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0};
      vecs[1] = {8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
      vecs[2] = {8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
      vecs[3] = {8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
      vecs[4] = {8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
      vecs[5] = {8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[6] = {8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[7] = {8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1};
      vecs[8] = {8'h00, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1};

      rst        = 1'b1;
      intf.start = 1'b0;
      intf.a     = 8'h00;
      intf.b     = 8'h00;
      intf.bin   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy", {31'b0, intf.busy}, 32'd0);
      check("reset_done", {31'b0, intf.done}, 32'd0);
      check("reset_diff", {24'b0, intf.diff}, 32'd0);
      check("reset_bout", {31'b0, intf.bout}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].bin, edges);
         check("vec_latency", edges, W);
         check("vec_diff", {24'b0, intf.diff}, {24'b0, vecs[i].d});
         check("vec_bout", {31'b0, intf.bout}, {31'b0, vecs[i].bo});
`ifdef SERIAL_SUB_OVF_EN
         check("vec_ovf", {31'b0, intf.ovf}, {31'b0, vecs[i].ov});
`endif
         check("vec_busy_at_done", {31'b0, intf.busy}, 32'd0);
         @(posedge clk);
         @(negedge clk);
         check("vec_done_one_cycle", {31'b0, intf.done}, 32'd0);
         check("vec_diff_held", {24'b0, intf.diff}, {24'b0, vecs[i].d});
      end

      // Starts during SHIFT and during DONE must be ignored.
      intf.a     = 8'h35;
      intf.b     = 8'h12;
      intf.bin   = 1'b0;
      intf.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      pulses = 0;
      dcyc   = -1;
      for (int c = 0; c < 30; c++) begin
         if (intf.done === 1'b1) begin
            pulses++;
            if (dcyc < 0) dcyc = c;
         end
         s          = (c == 3) || (intf.done === 1'b1);
         intf.start = s;
         intf.a     = s ? 8'hFF : 8'h35;
         intf.b     = s ? 8'h00 : 8'h12;
         @(posedge clk);
         @(negedge clk);
      end
      intf.start = 1'b0;
      check("ign_done_pulses", pulses, 1);
      check("ign_done_cycle", dcyc, W);
      check("ign_diff", {24'b0, intf.diff}, 32'h23);
      check("ign_bout", {31'b0, intf.bout}, 32'd0);
      check("ign_busy", {31'b0, intf.busy}, 32'd0);

      // Reset three cycles into SHIFT discards the operation.
      intf.a     = 8'h35;
      intf.b     = 8'h12;
      intf.bin   = 1'b0;
      intf.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      intf.start = 1'b0;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_mid_busy", {31'b0, intf.busy}, 32'd0);
      check("rst_mid_done", {31'b0, intf.done}, 32'd0);
      check("rst_mid_diff", {24'b0, intf.diff}, 32'd0);
      check("rst_mid_bout", {31'b0, intf.bout}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
      check("rst_mid_ovf", {31'b0, intf.ovf}, 32'd0);
`endif
      rst = 1'b0;
      @(negedge clk);
      check("rst_idle_busy", {31'b0, intf.busy}, 32'd0);
      do_op(8'h05, 8'h03, 1'b0, edges);
      check("rst_fresh_latency", edges, W);
      check("rst_fresh_diff", {24'b0, intf.diff}, 32'h02);
      check("rst_fresh_bout", {31'b0, intf.bout}, 32'd0);
      @(posedge clk);
      @(negedge clk);

      // Back-to-back with start held high.
      ca         = 8'($urandom);
      cb         = 8'($urandom);
      cbin       = 1'($urandom);
      intf.a     = ca;
      intf.b     = cb;
      intf.bin   = cbin;
      intf.start = 1'b1;
      cyc        = 0;
      last       = -1;
      for (int n = 0; n < 256; n++) begin
         k = 0;
         do begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            k++;
         end while (intf.done !== 1'b1 && k < 40);
         check("b2b_done_seen", {31'b0, intf.done}, 32'd1);
         m = model(ca, cb, cbin);
         check("b2b_diff", {24'b0, intf.diff}, {24'b0, m[7:0]});
         check("b2b_bout", {31'b0, intf.bout}, {31'b0, m[8]});
`ifdef SERIAL_SUB_OVF_EN
         check("b2b_ovf", {31'b0, intf.ovf}, {31'b0, m[9]});
`endif
         if (n > 0) check("b2b_spacing", cyc - last, W + 2);
         last     = cyc;
         ca       = 8'($urandom);
         cb       = 8'($urandom);
         cbin     = 1'($urandom);
         intf.a   = ca;
         intf.b   = cb;
         intf.bin = cbin;
      end
      intf.start = 1'b0;
      repeat (W + 4) @(posedge clk);
      @(negedge clk);
      check("final_idle_busy", {31'b0, intf.busy}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
